// File: rtl/inst_fetch_buffer_if.sv
// Fetch-buffer bundle: ROM fetch port, execute redirect and the {pc, inst} stream to decode.
// master = the fetch buffer itself, slave = ROM/execute/decoder side.
interface inst_fetch_buffer_if;
    logic [31:0] rom_a;
    logic [31:0] rom_inst;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        ifb_valid;
    logic [31:0] ifb_inst;
    logic [31:0] ifb_pc;
    logic        ifb_ready;
    logic        ifb_vec;

    modport master (
        output rom_a, ifb_valid, ifb_inst, ifb_pc, ifb_vec,
        input  rom_inst, redirect, redirect_pc, ifb_ready
    );

    modport slave (
        input  rom_a, ifb_valid, ifb_inst, ifb_pc, ifb_vec,
        output rom_inst, redirect, redirect_pc, ifb_ready
    );
endinterface

// File: rtl/inst_fetch_buffer.sv
// Instruction fetch buffer: sequential prefetch of a combinational ROM into a DEPTH-entry FIFO,
// flushed and re-steered on redirect. Optional vector/AES predecode bit: define IFB_PREDECODE_EN.
module inst_fetch_buffer #(
    parameter int unsigned DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic                clk,
    input  logic                clrn,
    inst_fetch_buffer_if.master bus
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);
`ifdef IFB_PREDECODE_EN
    localparam int unsigned EW = 65;
`else
    localparam int unsigned EW = 64;
`endif

    logic [31:0]   fetch_pc_q, fetch_pc_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [EW-1:0] mem_q [DEPTH];

    logic [31:0]   redirect_pc_al;
    logic          head_valid;
    logic          pop;
    logic          push;
    logic          wr_en;
    logic [PW-1:0] wr_addr;
    logic [EW-1:0] wr_entry;
    logic [EW-1:0] head_entry;

`ifdef IFB_PREDECODE_EN
    // OP-V, AES custom-2, or LOAD-FP/STORE-FP with a vector width encoding.
    function automatic logic is_vec_inst(input logic [31:0] w);
        logic [2:0] f3;
        f3 = w[14:12];
        case (w[6:0])
            7'b1010111, 7'b1011011: is_vec_inst = 1'b1;
            7'b0000111, 7'b0100111: is_vec_inst = (f3 == 3'b000) || (f3 >= 3'b101);
            default:                is_vec_inst = 1'b0;
        endcase
    endfunction
`endif

    assign redirect_pc_al = bus.redirect_pc & 32'hFFFF_FFFC;
    assign bus.rom_a      = bus.redirect ? redirect_pc_al : fetch_pc_q;

    assign head_valid = (count_q != '0);
    assign pop        = head_valid & bus.ifb_ready & ~bus.redirect;
    assign push       = ~bus.redirect & ((count_q < CW'(DEPTH)) | pop);

    // A redirect always lands in slot 0 of a freshly emptied FIFO.
    assign wr_en   = bus.redirect | push;
    assign wr_addr = bus.redirect ? '0 : wr_ptr_q;

    // rom_a already equals the pc of whatever is being written this cycle.
`ifdef IFB_PREDECODE_EN
    assign wr_entry = {is_vec_inst(bus.rom_inst), bus.rom_a, bus.rom_inst};
`else
    assign wr_entry = {bus.rom_a, bus.rom_inst};
`endif

    always_comb begin
        fetch_pc_d = fetch_pc_q;
        rd_ptr_d   = rd_ptr_q;
        wr_ptr_d   = wr_ptr_q;
        count_d    = count_q;
        if (bus.redirect) begin
            fetch_pc_d = redirect_pc_al + 32'd4;
            rd_ptr_d   = '0;
            wr_ptr_d   = PW'(1);
            count_d    = CW'(1);
        end else begin
            if (push) begin
                fetch_pc_d = fetch_pc_q + 32'd4;
                wr_ptr_d   = wr_ptr_q + PW'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PW'(1);
            end
            count_d = count_q + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk or negedge clrn) begin
        if (!clrn) begin
            fetch_pc_q <= RESET_PC;
            rd_ptr_q   <= '0;
            wr_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            rd_ptr_q   <= rd_ptr_d;
            wr_ptr_q   <= wr_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage needs no reset: the head is masked to zero whenever count is zero.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem_q[wr_addr] <= wr_entry;
        end
    end

    assign head_entry    = mem_q[rd_ptr_q];
    assign bus.ifb_valid = head_valid;
    assign bus.ifb_inst  = head_valid ? head_entry[31:0]  : 32'd0;
    assign bus.ifb_pc    = head_valid ? head_entry[63:32] : 32'd0;
`ifdef IFB_PREDECODE_EN
    assign bus.ifb_vec   = head_valid & head_entry[64];
`else
    assign bus.ifb_vec   = 1'b0;
`endif

endmodule

// File: tb/tb_inst_fetch_buffer.sv
// Self-checking bench for inst_fetch_buffer: directed scenarios plus randomized ready/redirect/reset
// traffic, checked against a queue-based reference model of the fetch stream.
module tb_inst_fetch_buffer;
    localparam int unsigned DEPTH = 4;
    localparam logic [31:0] RPC   = 32'h0000_0000;

    logic clk  = 1'b0;
    logic clrn = 1'b0;
    always #5 clk = ~clk;

    inst_fetch_buffer_if bus ();

    inst_fetch_buffer #(.DEPTH(DEPTH), .RESET_PC(RPC)) dut (
        .clk  (clk),
        .clrn (clrn),
        .bus  (bus)
    );

    // ROM model: A000_0000|a in low memory, hashed words higher up to vary opcodes.
    function automatic logic [31:0] rom_fn(input logic [31:0] a);
`ifdef IFB_PREDECODE_EN
        if (a == 32'h0C) return 32'h0202E107;
        if (a == 32'h30) return 32'h8223C15B;
        if (a == 32'h34) return 32'hFE9FF06F;
`endif
        if (a >= 32'h1000) return a * 32'h9E3779B1;
        return 32'hA000_0000 | a;
    endfunction

    assign bus.rom_inst = rom_fn(bus.rom_a);

    function automatic logic exp_vec(input logic [31:0] w);
`ifdef IFB_PREDECODE_EN
        logic [6:0] opc;
        logic [2:0] f3;
        opc = w[6:0];
        f3  = w[14:12];
        if (opc == 7'h57 || opc == 7'h5B) return 1'b1;
        if ((opc == 7'h07 || opc == 7'h27) && (f3 == 3'd0 || f3 == 3'd5 || f3 == 3'd6 || f3 == 3'd7))
            return 1'b1;
        return 1'b0;
`else
        return 1'b0 & w[0];
`endif
    endfunction

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
    } ent_t;

    ent_t        q[$];
    logic [31:0] m_fp;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_head();
        if (q.size() == 0) begin
            check("valid_empty", bus.ifb_valid, 32'd0);
            check("inst_empty",  bus.ifb_inst,  32'd0);
            check("pc_empty",    bus.ifb_pc,    32'd0);
            check("vec_empty",   bus.ifb_vec,   32'd0);
        end else begin
            check("valid", bus.ifb_valid, 32'd1);
            check("pc",    bus.ifb_pc,    q[0].pc);
            check("inst",  bus.ifb_inst,  q[0].inst);
            check("vec",   bus.ifb_vec,   exp_vec(q[0].inst));
        end
    endtask

    // Entered and left at a negedge; one clock of traffic with the given inputs.
    task automatic step(input logic rdy, input logic rd, input logic [31:0] rpc);
        logic [31:0] al;
        logic        pop;
        check_head();
        bus.ifb_ready   = rdy;
        bus.redirect    = rd;
        bus.redirect_pc = rpc;
        al = {rpc[31:2], 2'b00};
        #1;
        check("rom_a", bus.rom_a, rd ? al : m_fp);
        @(posedge clk);
        pop = (q.size() > 0) && rdy && !rd;
        if (rd) begin
            q.delete();
            q.push_back('{pc: al, inst: rom_fn(al)});
            m_fp = al + 32'd4;
            $display("redirect to %h", al);
        end else begin
            if (pop) begin
                $display("accept pc=%h inst=%h", q[0].pc, q[0].inst);
                void'(q.pop_front());
            end
            if (q.size() < DEPTH) begin
                q.push_back('{pc: m_fp, inst: rom_fn(m_fp)});
                m_fp = m_fp + 32'd4;
            end
        end
        @(negedge clk);
    endtask

    // Asynchronous reset pulse starting just after a negedge; head must vanish without a clock.
    task automatic pulse_reset();
        bus.redirect  = 1'b0;
        bus.ifb_ready = 1'b0;
        #2;
        clrn = 1'b0;
        #1;
        q.delete();
        m_fp = RPC;
        check("rst_valid", bus.ifb_valid, 32'd0);
        check("rst_pc",    bus.ifb_pc,    32'd0);
        check("rst_rom_a", bus.rom_a,     RPC);
        @(negedge clk);
        clrn = 1'b1;
        $display("reset pulse, restart at %h", RPC);
    endtask

    initial begin
        bus.ifb_ready   = 1'b0;
        bus.redirect    = 1'b0;
        bus.redirect_pc = 32'd0;
        m_fp            = RPC;
        repeat (2) @(negedge clk);
        check_head();
        check("reset_rom_a", bus.rom_a, RPC);
        clrn = 1'b1;

        // Stall after reset: FIFO saturates at DEPTH entries, head stays at RESET_PC.
        repeat (10) step(1'b0, 1'b0, 32'd0);
        check("sat_rom_a", bus.rom_a, 32'h10);
        check("sat_head",  bus.ifb_pc, 32'h0);
        repeat (8) step(1'b1, 1'b0, 32'd0);

        // Fill, then redirect to a misaligned target while full.
        repeat (4) step(1'b0, 1'b0, 32'd0);
        step(1'b0, 1'b1, 32'h0000_001E);
        check("redir_pc",   bus.ifb_pc,   32'h1C);
        check("redir_inst", bus.ifb_inst, 32'hA000_001C);
        step(1'b0, 1'b0, 32'd0);
        check("redir_hold", bus.ifb_pc, 32'h1C);

        // Redirect while the head is being offered and accepted.
        step(1'b1, 1'b1, 32'h0000_0040);
        repeat (4) step(1'b1, 1'b0, 32'd0);

        // Predecode targets, then a wrap across 32'hFFFF_FFFC.
        step(1'b0, 1'b1, 32'h0000_0030);
        repeat (3) step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'h0000_000C);
        repeat (2) step(1'b1, 1'b0, 32'd0);
        step(1'b1, 1'b1, 32'hFFFF_FFF4);
        repeat (6) step(1'b1, 1'b0, 32'd0);

        // Reset mid-stream with three entries held.
        step(1'b0, 1'b1, 32'h0000_0100);
        repeat (2) step(1'b0, 1'b0, 32'd0);
        pulse_reset();
        repeat (5) step(1'b1, 1'b0, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 600; i++) begin
            logic        rdy;
            logic        rd;
            logic [31:0] rpc;
            rdy = ($urandom_range(0, 99) < 70);
            rd  = ($urandom_range(0, 99) < 10);
            case ($urandom_range(0, 3))
                0:       rpc = $urandom_range(0, 255);
                1:       rpc = 32'hFFFF_FFF0 | $urandom_range(0, 15);
                default: rpc = $urandom;
            endcase
            if ($urandom_range(0, 199) == 0) pulse_reset();
            else step(rdy, rd, rpc);
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end
endmodule
